// File: rtl/fft_ctrl_pkg.sv
// Shared types and default sizes for the FFT frame controller.
// The ERR state is present only when FFT_FRAME_CTRL_WATCHDOG_EN is defined.
package fft_ctrl_pkg;

  localparam int FFT_N_POINTS = 32;
  localparam int FFT_ADDR_W   = 5;
  localparam int FFT_DATA_W   = 16;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_START  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_UNLOAD = 3'd4
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
    ,
    ST_ERR    = 3'd5
`endif
  } fft_state_e;

  typedef struct packed {
    logic [FFT_DATA_W-1:0] re;
    logic [FFT_DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_out_fifo2.sv
// Two-entry result buffer for the unload path; exposes its occupancy so the
// read issuer can keep reads in flight from overrunning it.
module fft_out_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT core: load samples, pulse start, wait for done, drain, unload.
// Define FFT_FRAME_CTRL_WATCHDOG_EN to add the RUN watchdog, the ERR state and the wdog_err port.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N_POINTS       = FFT_N_POINTS,
  parameter int ADDR_W         = FFT_ADDR_W,
  parameter int DATA_W         = FFT_DATA_W,
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
  parameter int TIMEOUT_CYCLES = 4096,
`endif
  parameter int DRAIN_CYCLES   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              load_data_write,
  output logic [ADDR_W-1:0] load_data_addr,
  output logic [DATA_W-1:0] data_real_in,
  output logic [DATA_W-1:0] data_imag_in,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_real,
  input  logic [DATA_W-1:0] rd_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_last,
  output logic              busy,
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
  output logic              wdog_err,
`endif
  output logic [15:0]       frame_cnt
);

  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);
  localparam int FW   = 2 * DATA_W + 1;

  fft_state_e        r_state;
  logic [ADDR_W-1:0] r_ld_cnt;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [DR_W-1:0]   r_dr_cnt;
  logic              r_done_armed;
  logic              r_ld_write;
  logic [ADDR_W-1:0] r_ld_addr;
  logic [DATA_W-1:0] r_ld_re;
  logic [DATA_W-1:0] r_ld_im;
  logic              r_fft_start;
  logic              r_rd_pend;
  logic              r_rd_pend_last;
  logic [15:0]       r_frame_cnt;
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]   r_wd_cnt;
`endif

  logic              w_fifo_valid;
  logic [1:0]        w_occ;
  logic [FW-1:0]     w_fifo_head;
  logic              w_pop;
  logic [2:0]        w_credit;
  logic              w_rd_en;

  // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
  // valid never waits on ready. A result popped this cycle frees its slot for a new read,
  // which is what allows one result per cycle through a two-entry buffer.
  assign w_pop    = w_fifo_valid && out_ready;
  assign w_credit = {1'b0, w_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_rd_en  = (r_state == ST_UNLOAD) && (r_rd_cnt < (ADDR_W+1)'(N_POINTS))
                    && (w_credit < 3'd2);

  fft_out_fifo2 #(.W(FW)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_pend),
    .i_data  ({r_rd_pend_last, rd_real, rd_imag}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_head),
    .o_occ   (w_occ)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_LOAD;
      r_ld_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_dr_cnt       <= '0;
      r_done_armed   <= 1'b0;
      r_ld_write     <= 1'b0;
      r_ld_addr      <= '0;
      r_ld_re        <= '0;
      r_ld_im        <= '0;
      r_fft_start    <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_pend_last <= 1'b0;
      r_frame_cnt    <= '0;
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
      r_wd_cnt       <= '0;
`endif
    end else begin
      r_ld_write     <= 1'b0;
      r_fft_start    <= 1'b0;
      r_rd_pend      <= w_rd_en;
      r_rd_pend_last <= w_rd_en && (r_rd_cnt == (ADDR_W+1)'(N_POINTS - 1));
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_ld_write <= 1'b1;
            r_ld_addr  <= r_ld_cnt;
            r_ld_re    <= in_real;
            r_ld_im    <= in_imag;
            if (r_ld_cnt == ADDR_W'(N_POINTS - 1)) begin
              r_ld_cnt     <= '0;
              r_done_armed <= 1'b0;
              r_state      <= ST_START;
            end else begin
              r_ld_cnt <= r_ld_cnt + ADDR_W'(1);
            end
          end
        end
        ST_START: begin
          r_fft_start <= 1'b1;
          if (!fft_done) r_done_armed <= 1'b1;
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // The core has no reset, so a done level left over from an earlier frame
          // only counts once it has been seen low since START.
          if (fft_done && r_done_armed) begin
            r_dr_cnt <= DR_W'(1);
            r_state  <= ST_DRAIN;
          end else begin
            if (!fft_done) r_done_armed <= 1'b1;
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
            if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) r_state <= ST_ERR;
            else r_wd_cnt <= r_wd_cnt + WD_W'(1);
`endif
          end
        end
        ST_DRAIN: begin
          // The done cycle counts as drain cycle 0, so DRAIN_CYCLES must be at least 2.
          if (r_dr_cnt == DR_W'(DRAIN_CYCLES - 1)) r_state <= ST_UNLOAD;
          else r_dr_cnt <= r_dr_cnt + DR_W'(1);
        end
        ST_UNLOAD: begin
          if (w_rd_en) r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
          if (w_pop && w_fifo_head[FW-1]) begin
            r_rd_cnt    <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= ST_LOAD;
          end
        end
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
        ST_ERR: r_state <= ST_ERR;
`endif
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign in_ready        = (r_state == ST_LOAD);
  assign load_data_write = r_ld_write;
  assign load_data_addr  = r_ld_addr;
  assign data_real_in    = r_ld_re;
  assign data_imag_in    = r_ld_im;
  assign fft_start       = r_fft_start;
  assign rd_en           = w_rd_en;
  assign rd_addr         = r_rd_cnt[ADDR_W-1:0];
  assign out_valid       = w_fifo_valid && (r_state == ST_UNLOAD);
  assign out_last        = w_fifo_head[FW-1];
  assign out_real        = w_fifo_head[2*DATA_W-1:DATA_W];
  assign out_imag        = w_fifo_head[DATA_W-1:0];
  assign busy            = !((r_state == ST_LOAD) && (r_ld_cnt == '0));
  assign frame_cnt       = r_frame_cnt;
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
  assign wdog_err        = (r_state == ST_ERR);
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed/random bench for fft_frame_ctrl with a behavioural FFT-core model and scoreboard.
// Define FFT_FRAME_CTRL_WATCHDOG_EN to also cover the RUN watchdog.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int N      = 32;
  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int DRAIN  = 10;
  localparam int LD_W   = AW + 2 * DW;
  localparam int OUT_W  = 1 + 2 * DW;
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
  localparam int DONE_DLY = 40;
`else
  localparam int DONE_DLY = 100;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          in_valid, in_ready;
  logic [DW-1:0] in_real, in_imag;
  logic          load_data_write;
  logic [AW-1:0] load_data_addr;
  logic [DW-1:0] data_real_in, data_imag_in;
  logic          fft_start, fft_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_real, rd_imag;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_real, out_imag;
  logic          busy;
  logic [15:0]   frame_cnt;
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
  logic          wdog_err;
`endif

  fft_frame_ctrl #(
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
    .TIMEOUT_CYCLES (64),
`endif
    .DRAIN_CYCLES   (DRAIN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_real         (in_real),
    .in_imag         (in_imag),
    .load_data_write (load_data_write),
    .load_data_addr  (load_data_addr),
    .data_real_in    (data_real_in),
    .data_imag_in    (data_imag_in),
    .fft_start       (fft_start),
    .fft_done        (fft_done),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_real         (rd_real),
    .rd_imag         (rd_imag),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_real        (out_real),
    .out_imag        (out_imag),
    .out_last        (out_last),
    .busy            (busy),
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
    .wdog_err        (wdog_err),
`endif
    .frame_cnt       (frame_cnt)
  );

  // FFT core model: result memory read with one cycle of latency
  cplx_t smp [N];
  cplx_t res [N];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_real <= res[rd_addr].re;
      rd_imag <= res[rd_addr].im;
    end
  end

  // scoreboard
  logic [LD_W-1:0]  ld_exp_q[$];
  logic [LD_W-1:0]  ld_obs_q[$];
  logic [OUT_W-1:0] out_exp_q[$];
  logic [OUT_W-1:0] out_obs_q[$];
  int n_asserts = 0;
  int n_fail    = 0;
  int start_cnt, start_cyc, last_wr_cyc, first_rd_cyc, first_out_cyc, last_out_cyc;
  int n_rd, n_pop, credit_viol, done_cyc, exp_frames;

  always @(negedge clk) begin
    if (rst_n) begin
      if (load_data_write) begin
        ld_obs_q.push_back({load_data_addr, data_real_in, data_imag_in});
        last_wr_cyc = cyc;
      end
      if (fft_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (n_rd - n_pop - ((out_valid && out_ready) ? 1 : 0) >= 2) credit_viol++;
        n_rd++;
      end
      if (out_valid && out_ready) begin
        out_obs_q.push_back({out_last, out_real, out_imag});
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        n_pop++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame(input bit random_data);
    ld_exp_q.delete(); ld_obs_q.delete(); out_exp_q.delete(); out_obs_q.delete();
    start_cnt = 0; start_cyc = -1; last_wr_cyc = -1; first_rd_cyc = -1;
    first_out_cyc = -1; last_out_cyc = -1; n_rd = 0; n_pop = 0; credit_viol = 0;
    for (int k = 0; k < N; k++) begin
      smp[k].re = random_data ? DW'($urandom) : DW'(k);
      smp[k].im = random_data ? DW'($urandom) : DW'(-k);
      res[k].re = DW'($urandom);
      res[k].im = DW'($urandom);
      ld_exp_q.push_back({AW'(k), smp[k].re, smp[k].im});
      out_exp_q.push_back({(k == N - 1), res[k].re, res[k].im});
    end
  endtask

  task automatic load_frame(input bit gaps, input bit hold);
    int k = 0;
    int guard = 0;
    bit hs;
    while (k < N && guard < 400) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_real  = smp[k].re;
        in_imag  = smp[k].im;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      guard++;
      if (hs) k++;
    end
    chk("load_accepted", k, N);
    if (hold) begin
      in_real = 16'hDEAD;
      in_imag = 16'hBEEF;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20 && start_cnt == 0; i++) tick();
    chk("start_seen", start_cnt, 1);
  endtask

  task automatic raise_done(input int dly);
    while (cyc < start_cyc + dly) tick();
    fft_done = 1'b1;
    done_cyc = cyc;
  endtask

  task automatic unload(input bit rand_ready, input int stop_at);
    for (int i = 0; i < 3000 && out_obs_q.size() < stop_at; i++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
  endtask

  task automatic check_frame();
    repeat (4) tick();
    chk("ld_count", ld_obs_q.size(), N);
    for (int i = 0; i < N; i++)
      if (i < ld_obs_q.size()) chk("ld_entry", ld_obs_q[i], ld_exp_q[i]);
    chk("out_count", out_obs_q.size(), N);
    for (int i = 0; i < N; i++)
      if (i < out_obs_q.size()) chk("out_entry", out_obs_q[i], out_exp_q[i]);
    chk("start_pulses", start_cnt, 1);
    chk("start_after_last_write", start_cyc - last_wr_cyc, 1);
    chk("read_credit", credit_viol, 0);
    chk("frame_cnt", frame_cnt, exp_frames);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load_write"}, load_data_write, 0);
    chk({tag, "_load_addr"}, load_data_addr, 0);
    chk({tag, "_fft_start"}, fft_start, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_real"}, out_real, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed cycle %0d expected end of test", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
    fft_done = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // frame 1: ramp samples, in_valid held high, out_ready high, done 100 cycles after start
    new_frame(1'b0);
    load_frame(1'b0, 1'b1);
    wait_start();
    chk("run_in_ready", in_ready, 0);
    raise_done(DONE_DLY);
    in_valid = 1'b0;
    unload(1'b0, N);
    chk("drain_gap_f1", first_rd_cyc - done_cyc, DRAIN);
    chk("first_out_latency", first_out_cyc - first_rd_cyc, 2);
    chk("full_rate_burst", last_out_cyc - first_out_cyc, N - 1);
    exp_frames = 1;
    check_frame();

    // frame 2: random samples with input gaps, random output back-pressure
    new_frame(1'b1);
    fft_done = 1'b0;
    load_frame(1'b1, 1'b0);
    wait_start();
    raise_done($urandom_range(20, 60));
    unload(1'b1, N);
    chk("drain_gap_f2", first_rd_cyc - done_cyc, DRAIN);
    exp_frames = 2;
    check_frame();

    // frame 3: done still high from before START must be ignored until it drops
    new_frame(1'b1);
    fft_done = 1'b1;
    load_frame(1'b0, 1'b0);
    wait_start();
    repeat (30) tick();
    chk("stale_done_no_read", first_rd_cyc, -1);
    chk("stale_done_busy", busy, 1);
    fft_done = 1'b0;
    repeat (5) tick();
    fft_done = 1'b1;
    done_cyc = cyc;
    unload(1'b1, N);
    chk("drain_gap_f3", first_rd_cyc - done_cyc, DRAIN);
    exp_frames = 3;
    check_frame();

    // frame 4: reset in the middle of unload
    new_frame(1'b0);
    fft_done = 1'b0;
    load_frame(1'b0, 1'b0);
    wait_start();
    raise_done(40);
    unload(1'b0, 7);
    chk("frame_cnt_pre_reset", frame_cnt, 3);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("mid_unload_reset");
    tick();
    rst_n = 1'b1;

    // frame 5: after reset, core done level is stale; frame must still complete
    new_frame(1'b1);
    load_frame(1'b1, 1'b0);
    wait_start();
    repeat (3) tick();
    fft_done = 1'b0;
    raise_done($urandom_range(20, 50));
    unload(1'b1, N);
    chk("drain_gap_f5", first_rd_cyc - done_cyc, DRAIN);
    exp_frames = 1;
    check_frame();

`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
    // watchdog: done never arrives
    new_frame(1'b0);
    fft_done = 1'b0;
    load_frame(1'b0, 1'b0);
    wait_start();
    while (cyc < start_cyc + 63) tick();
    chk("wdog_not_yet", wdog_err, 0);
    tick();
    chk("wdog_set", wdog_err, 1);
    chk("wdog_in_ready", in_ready, 0);
    chk("wdog_busy", busy, 1);
    chk("wdog_out_valid", out_valid, 0);
    repeat (20) tick();
    chk("wdog_sticky", wdog_err, 1);
    rst_n = 1'b0;
    tick();
    chk("wdog_cleared", wdog_err, 0);
    rst_n = 1'b1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
